uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver. Captures each
//  completed frame (ready pulse) into a FWFT FIFO. Presents bytes to the host logic
//  over a valid/ready handshake. Tracks overrun and framing-error events for status readout.
// PARAMETERS
//  AddrWidth   4    FIFO depth = 2**AddrWidth entries of 8 bits
//  ErrCntWidth 8    width of saturating framing-error counter
//  IdleCycles  1024 ref_clk cycles without a new byte before idle asserts (IDLE feature only)
// PORTS
//  ref_clk      in   1            system clock; all logic on posedge
//  reset        in   1            one clock; reset is asynchronous and active-low
//  clear        in   1            sync flush: empties FIFO, clears overrun and err_cnt
//  rx_data      in   [0:7]        byte from receiver; sampled only when rx_ready=1
//  rx_ready     in   1            1-cycle pulse: rx_data holds a valid frame
//  rx_err       in   1            1-cycle pulse: framing error, no byte delivered
//  dout         out  [0:7]        head-of-FIFO byte; valid while dout_valid=1
//  dout_valid   out  1            FIFO non-empty
//  dout_ready   in   1            consumer accepts dout this cycle
//  count        out  AddrWidth+1  current occupancy, 0..2**AddrWidth
//  full         out  1            count==2**AddrWidth
//  overrun      out  1            sticky: a byte arrived while full and was dropped
//  err_cnt      out  ErrCntWidth  saturating count of rx_err pulses
//  idle         out  1            IDLE feature only; tied 0 otherwise
// BEHAVIOUR
//  - Reset (reset=0, async): wr/rd pointers=0, count=0, dout_valid=0, full=0,
//    overrun=0, err_cnt=0, idle=0, dout=8'h00. Memory contents are don't-care.
//  - rx_data bit order is preserved index-for-index into dout (dout[i]=rx_data[i]).
//  - push = rx_ready & (~full | pop); pop = dout_valid & dout_ready.
//  - Push writes mem[wr_ptr], wr_ptr+1 (wraps mod 2**AddrWidth). Pop advances rd_ptr (wraps).
//  - count: +1 on push only, -1 on pop only, unchanged on both/neither.
//  - FWFT: dout = mem[rd_ptr] registered; a push into an empty FIFO gives dout_valid=1
//    on the following edge (latency 1 cycle from rx_ready to dout_valid).
//  - Full + rx_ready + pop same cycle: byte accepted, count stays 2**AddrWidth, no overrun.
//  - Full + rx_ready without pop: byte dropped, overrun<=1 (sticky until clear/reset).
//  - Empty + dout_ready: no effect; pointers and count unchanged.
//  - rx_err: err_cnt+1, saturates at all-ones; FIFO untouched. rx_err and rx_ready together
//    (not produced by receiver): both actions taken independently.
//  - clear=1: next edge pointers=0, count=0, dout_valid=0, overrun=0, err_cnt=0; any
//    simultaneous push/pop/rx_err ignored. clear has priority over all other inputs.
//  - No FSM beyond pointer/count registers; full and dout_valid are derived from count.
// CONFIGURATION
//  UART_RX_FIFO_IDLE_EN defined: a ref_clk counter of width $clog2(IdleCycles+1) clears on
//    push or clear, else increments while count!=0, saturating at IdleCycles. idle=1
//    while count!=0 and counter==IdleCycles; drops the cycle after the FIFO empties or a
//    push occurs. Lets the host drain partial messages on line silence.
//  Undefined: no counter logic; idle tied 0.
// TESTING
//  1 reset release, pulse rx_ready with rx_data=8'hA5 -> next cycle dout_valid=1, dout=A5, count=1
//  2 push 16 bytes 0..15 (AddrWidth=4), dout_ready=0 -> full=1; 17th push -> overrun=1,
//    count=16; then drain -> bytes 0..15 in order, byte 16 absent
//  3 full FIFO, rx_ready and dout_ready same cycle -> count stays 16, overrun=0, new byte last out
//  4 300 rx_err pulses (ErrCntWidth=8) -> err_cnt=255; clear pulse -> err_cnt=0, count=0,
//    overrun=0
//  5 assert reset=0 asynchronously mid-burst with 5 bytes queued -> all outputs at reset
//    values immediately, before next edge
//  6 IDLE_EN, IdleCycles=8: push 1 byte, hold dout_ready=0 -> idle=1 at 8 cycles after push;
//    pop -> idle=0 next cycle

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver with overrun and framing-error status.
// Optional line-silence detector enabled by defining UART_RX_FIFO_IDLE_EN.
module uart_rx_fifo #(
    parameter int AddrWidth   = 4,
    parameter int ErrCntWidth = 8,
    parameter int IdleCycles  = 1024
) (
    input  logic                   ref_clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [0:7]             rx_data,
    input  logic                   rx_ready,
    input  logic                   rx_err,
    output logic [0:7]             dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [AddrWidth:0]     count,
    output logic                   full,
    output logic                   overrun,
    output logic [ErrCntWidth-1:0] err_cnt,
    output logic                   idle
);

    localparam int Depth = 2 ** AddrWidth;
    localparam logic [AddrWidth:0] FullCount = {1'b1, {AddrWidth{1'b0}}};

    logic [0:7]           mem [Depth];
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth-1:0] rd_next;
    logic                 push;
    logic                 pop;

    assign dout_valid = (count != '0);
    assign full       = (count == FullCount);
    assign pop        = dout_valid & dout_ready;
    assign push       = rx_ready & (~full | pop);
    assign rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge ref_clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            err_cnt <= '0;
            dout    <= 8'h00;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            err_cnt <= '0;
            dout    <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (rx_ready && full && !pop) begin
                overrun <= 1'b1;
            end
            if (rx_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            // A write landing on the next head slot bypasses the memory so dout is never stale.
            dout <= (push && (wr_ptr == rd_next)) ? rx_data : mem[rd_next];
        end
    end

`ifdef UART_RX_FIFO_IDLE_EN
    localparam int IdleW = $clog2(IdleCycles + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleCycles);

    logic [IdleW-1:0] idle_cnt;

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (clear || push) begin
            idle_cnt <= '0;
        end else if (dout_valid && (idle_cnt != IdleMax)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign idle = dout_valid && (idle_cnt == IdleMax);
`else
    // Without the silence timer idle is constant low.
    assign idle = 1'b0 && (IdleCycles > 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model plus a decoupled output monitor.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int IDLE  = 8;

    logic       ref_clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic [0:7] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_err = 1'b0;
    logic [0:7] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       overrun;
    logic [7:0] err_cnt;
    logic       idle;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovr = 1'b0;
    int         m_err = 0;
    int         cyc = 0;
    int         last_push = 0;

    uart_rx_fifo #(.AddrWidth(4), .ErrCntWidth(8), .IdleCycles(IDLE)) dut (
        .ref_clk(ref_clk), .reset(reset), .clear(clear),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_err(rx_err),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .count(count), .full(full), .overrun(overrun),
        .err_cnt(err_cnt), .idle(idle)
    );

    initial forever #5 ref_clk = ~ref_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_idle();
`ifdef UART_RX_FIFO_IDLE_EN
        return (m_q.size() > 0 && (cyc - last_push) >= IDLE) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Reference model: FIFO as a queue, applied to the inputs seen at each rising edge.
    initial forever begin
        bit pop_m;
        bit push_m;
        @(posedge ref_clk or negedge reset);
        if (!reset) begin
            m_q.delete();
            exp_q.delete();
            m_ovr = 1'b0;
            m_err = 0;
        end else begin
            cyc++;
            if (clear) begin
                m_q.delete();
                exp_q.delete();
                m_ovr = 1'b0;
                m_err = 0;
            end else begin
                pop_m  = (m_q.size() > 0) && dout_ready;
                push_m = rx_ready && ((m_q.size() < DEPTH) || pop_m);
                if (pop_m) void'(m_q.pop_front());
                if (push_m) begin
                    m_q.push_back(rx_data);
                    exp_q.push_back(rx_data);
                    last_push = cyc;
                end
                if (rx_ready && !push_m) m_ovr = 1'b1;
                if (rx_err && m_err < 255) m_err++;
            end
        end
    end

    // Monitor: compares every accepted byte and the status outputs mid-cycle.
    initial forever begin
        logic [7:0] e;
        @(negedge ref_clk);
        if (dout_valid && dout_ready) begin
            chk("byte_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dout", int'(dout), int'(e));
            end
        end
        chk("count", int'(count), m_q.size());
        chk("dout_valid", int'(dout_valid), (m_q.size() > 0) ? 1 : 0);
        chk("full", int'(full), (m_q.size() == DEPTH) ? 1 : 0);
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("err_cnt", int'(err_cnt), m_err);
        chk("idle", int'(idle), exp_idle());
    end

    task automatic drive(input logic rr, input logic [7:0] d, input logic dr,
                         input logic re, input logic cl);
        rx_ready   = rr;
        rx_data    = d;
        dout_ready = dr;
        rx_err     = re;
        clear      = cl;
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_dout_valid"}, int'(dout_valid), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_idle"}, int'(idle), 0);
        chk({tag, "_dout"}, int'(dout), 0);
    endtask

    initial begin
        repeat (3) @(posedge ref_clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b1;

        // Single byte: visible one edge after rx_ready.
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", int'(dout_valid), 1);
        chk("t1_dout", int'(dout), 'hA5);
        chk("t1_count", int'(count), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fill, overflow by one, then drain in order.
        for (int i = 0; i < 17; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2_full", int'(full), 1);
        chk("t2_overrun", int'(overrun), 1);
        chk("t2_count", int'(count), 16);
        for (int i = 0; i < 18; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t2_drained", exp_q.size(), 0);
        chk("t2_overrun_sticky", int'(overrun), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("t3_count", int'(count), 16);
        chk("t3_overrun", int'(overrun), 0);
        for (int i = 0; i < 17; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Error counter saturation, then clear.
        for (int i = 0; i < 300; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t4_err_sat", int'(err_cnt), 255);
        drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        chk("t4_err_clr", int'(err_cnt), 0);
        chk("t4_count_clr", int'(count), 0);
        chk("t4_ovr_clr", int'(overrun), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) < 50) ? 1'b1 : 1'b0, 8'($urandom),
                  ($urandom_range(99) < ((i / 500) % 2 == 0 ? 35 : 70)) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 10) ? 1'b1 : 1'b0,
                  ($urandom_range(999) < 8) ? 1'b1 : 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with bytes queued.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b1, 1'b0);
        chk("t5_pre_count", int'(count), 5);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("t5");
        @(posedge ref_clk);
        #1;
        reset = 1'b1;

`ifdef UART_RX_FIFO_IDLE_EN
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_idle_early", int'(idle), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_idle_set", int'(idle), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t6_idle_drop", int'(idle), 0);
`else
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_idle_tied", int'(idle), 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("end_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
